// File: rtl/risc16ba_dbus_pkg.sv
// Shared constants and dump state encoding for the risc16ba data-side bus slave.
// Address defaults are overridable through the top-level parameters.
package risc16ba_dbus_pkg;

  localparam logic [15:0] LED_ADDR_LO_DEF = 16'h0200;
  localparam logic [15:0] LED_ADDR_HI_DEF = 16'h0202;
  localparam logic [15:0] DUMP_BASE_DEF   = 16'hc000;
  localparam logic [15:0] DUMP_LAST_DEF   = 16'hfffe;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } dump_state_t;

endpackage

// File: rtl/risc16ba_dbus_if.sv
// Core data port, LED output and dump stream of the risc16ba data bus.
// master = core/host side, slave = risc16ba_dbus.
interface risc16ba_dbus_if;

  logic [15:0] daddr;
  logic [15:0] ddout;
  logic [15:0] ddin;
  logic        doe;
  logic        dwe0;
  logic        dwe1;
  logic [23:0] led;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready;
  logic [15:0] dump_data;
  logic [15:0] dump_addr;
  logic        dump_done;
  logic [15:0] dump_sum;

  modport master (
    output daddr, ddout, doe, dwe0, dwe1, dump_start, dump_ready,
    input  ddin, led, dump_busy, dump_valid, dump_data, dump_addr, dump_done, dump_sum
  );

  modport slave (
    input  daddr, ddout, doe, dwe0, dwe1, dump_start, dump_ready,
    output ddin, led, dump_busy, dump_valid, dump_data, dump_addr, dump_done, dump_sum
  );

endinterface

// File: rtl/risc16ba_dump_fsm.sv
// Streams DUMP_BASE..DUMP_LAST as words: first beat 1 cycle after start, 1 word/cycle, held while !ready.
// RISC16_DUMP_CHECKSUM_EN adds a mod-2^16 sum of accepted words; otherwise sum_o is tied to zero.
module risc16ba_dump_fsm
  import risc16ba_dbus_pkg::*;
#(
  parameter logic [15:0] DUMP_BASE = DUMP_BASE_DEF,
  parameter logic [15:0] DUMP_LAST = DUMP_LAST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        ready_i,
  output logic [14:0] rd_waddr_o,
  input  logic [15:0] rd_data_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic        done_o,
  output logic [15:0] data_o,
  output logic [15:0] addr_o,
  output logic [15:0] sum_o
);

  dump_state_t state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] nxt_addr;
  logic        accept;
  logic        load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Last-word test is on the current address, so DUMP_LAST never wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = STREAM;
      STREAM:  if (ready_i && (addr_q == DUMP_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept     = (state_q == STREAM) && ready_i;
    load       = ((state_q == IDLE) && start_i) || (accept && (addr_q != DUMP_LAST));
    nxt_addr   = (state_q == IDLE) ? DUMP_BASE : addr_q + 16'd2;
    rd_waddr_o = nxt_addr[15:1];
    addr_d     = load ? nxt_addr : addr_q;
    data_d     = load ? rd_data_i : data_q;
    valid_o    = (state_q == STREAM);
    busy_o     = (state_q == STREAM);
    done_o     = (state_q == DONE);
  end

  assign data_o = data_q;
  assign addr_o = addr_q;

`ifdef RISC16_DUMP_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if ((state_q == IDLE) && start_i) sum_d = '0;
    else if (accept)                  sum_d = sum_q + data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_o = sum_q;
`else
  assign sum_o = 16'h0000;
`endif

endmodule

// File: rtl/risc16ba_dbus.sv
// risc16ba data-side slave: 64 KiB big-endian byte-lane memory, 24-bit LED register, dump engine.
// Reads are combinational; writes commit at the edge; optional checksum via RISC16_DUMP_CHECKSUM_EN.
module risc16ba_dbus
  import risc16ba_dbus_pkg::*;
#(
  parameter logic [15:0] LED_ADDR_LO = LED_ADDR_LO_DEF,
  parameter logic [15:0] LED_ADDR_HI = LED_ADDR_HI_DEF,
  parameter logic [15:0] DUMP_BASE   = DUMP_BASE_DEF,
  parameter logic [15:0] DUMP_LAST   = DUMP_LAST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  risc16ba_dbus_if.slave  bus_if
);

  // Even bytes (high half of a word) and odd bytes kept as separate banks.
  logic [7:0]  mem_hi_q [0:32767];
  logic [7:0]  mem_lo_q [0:32767];
  logic [14:0] waddr;
  logic        led_lo_hit;
  logic        led_hi_hit;
  logic [23:0] led_q, led_d;
  logic [15:0] rd_dat;
  logic [14:0] dump_waddr;
  logic [15:0] dump_rdata;
  logic        dump_busy, dump_valid, dump_done;
  logic [15:0] dump_data, dump_addr, dump_sum;

  assign waddr      = bus_if.daddr[15:1];
  assign led_lo_hit = (bus_if.daddr == LED_ADDR_LO);
  assign led_hi_hit = (bus_if.daddr == LED_ADDR_HI);

  always_ff @(posedge clk) begin
    if (bus_if.dwe0 && !led_lo_hit && !led_hi_hit) mem_hi_q[waddr] <= bus_if.ddout[15:8];
    if (bus_if.dwe1 && !led_lo_hit && !led_hi_hit) mem_lo_q[waddr] <= bus_if.ddout[7:0];
  end

  always_comb begin
    led_d = led_q;
    if (led_lo_hit && bus_if.dwe1) led_d[7:0]   = bus_if.ddout[7:0];
    if (led_lo_hit && bus_if.dwe0) led_d[15:8]  = bus_if.ddout[15:8];
    if (led_hi_hit && bus_if.dwe1) led_d[23:16] = bus_if.ddout[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  always_comb begin
    rd_dat = 16'h0000;
    if (bus_if.doe) begin
      if (led_lo_hit)      rd_dat = led_q[15:0];
      else if (led_hi_hit) rd_dat = {8'h00, led_q[23:16]};
      else                 rd_dat = {mem_hi_q[waddr], mem_lo_q[waddr]};
    end
  end

  // Dump port sees pre-edge contents, so a same-cycle core write is not captured.
  assign dump_rdata = {mem_hi_q[dump_waddr], mem_lo_q[dump_waddr]};

  risc16ba_dump_fsm #(
    .DUMP_BASE (DUMP_BASE),
    .DUMP_LAST (DUMP_LAST)
  ) u_dump_fsm (
    .clk        (clk),
    .rst        (rst),
    .start_i    (bus_if.dump_start),
    .ready_i    (bus_if.dump_ready),
    .rd_waddr_o (dump_waddr),
    .rd_data_i  (dump_rdata),
    .busy_o     (dump_busy),
    .valid_o    (dump_valid),
    .done_o     (dump_done),
    .data_o     (dump_data),
    .addr_o     (dump_addr),
    .sum_o      (dump_sum)
  );

  assign bus_if.ddin       = rd_dat;
  assign bus_if.led        = led_q;
  assign bus_if.dump_busy  = dump_busy;
  assign bus_if.dump_valid = dump_valid;
  assign bus_if.dump_done  = dump_done;
  assign bus_if.dump_data  = dump_data;
  assign bus_if.dump_addr  = dump_addr;
  assign bus_if.dump_sum   = dump_sum;

endmodule

// File: tb/tb_risc16ba_dbus.sv
// Directed bench for risc16ba_dbus: LED decode, byte lanes, full/stalled dumps, coherency, reset abort.
// Checksum expectations follow RISC16_DUMP_CHECKSUM_EN.
module tb_risc16ba_dbus;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] model [0:8191];

  risc16ba_dbus_if bus ();

  risc16ba_dbus dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic w0, input logic w1);
    bus.daddr = a;
    bus.ddout = d;
    bus.dwe0  = w0;
    bus.dwe1  = w1;
    step();
    bus.dwe0  = 1'b0;
    bus.dwe1  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.daddr = a;
    bus.doe   = 1'b1;
    #1;
    d = bus.ddin;
    bus.doe = 1'b0;
  endtask

  task automatic fill(input bit word_is_addr);
    logic [15:0] a, d;
    for (int i = 0; i < 8192; i++) begin
      a = 16'hc000 + 16'(2 * i);
      d = word_is_addr ? a : 16'h0001;
      wr(a, d, 1'b1, 1'b1);
      model[i] = d;
    end
  endtask

  task automatic run_dump(input bit stall, output int beats, output int seq_err, output int hold_err,
                          output int zero_cnt, output int done_gap, output logic [15:0] last_addr,
                          output logic [15:0] exp_sum, output logic [15:0] sum_at_done);
    int cyc, last_cyc, done_cyc;
    logic [15:0] exp_a, h_a, h_d;
    bit held;
    beats = 0; seq_err = 0; hold_err = 0; zero_cnt = 0;
    last_addr = '0; exp_sum = '0; sum_at_done = '0;
    exp_a = 16'hc000; held = 1'b0; h_a = '0; h_d = '0;
    last_cyc = -100; done_cyc = -1;
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    chk("first_vld", bus.dump_valid, 1);
    chk("first_addr", bus.dump_addr, 16'hc000);
    cyc = 0;
    while (cyc < 40000) begin
      if (bus.dump_done) begin
        done_cyc = cyc;
        sum_at_done = bus.dump_sum;
        break;
      end
      bus.dump_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.dump_valid) begin
        if (held && (bus.dump_addr !== h_a || bus.dump_data !== h_d)) hold_err++;
        if (bus.dump_addr == 16'h0000) zero_cnt++;
        if (bus.dump_ready) begin
          if (bus.dump_addr !== exp_a || bus.dump_data !== model[exp_a[13:1]]) seq_err++;
          exp_sum   = exp_sum + model[exp_a[13:1]];
          beats++;
          last_addr = bus.dump_addr;
          held      = 1'b0;
          if (bus.dump_addr == 16'hfffe) last_cyc = cyc;
          exp_a     = exp_a + 16'd2;
        end else begin
          held = 1'b1;
          h_a  = bus.dump_addr;
          h_d  = bus.dump_data;
        end
      end
      step();
      cyc++;
    end
    bus.dump_ready = 1'b0;
    done_gap = (done_cyc < 0) ? -1 : done_cyc - last_cyc;
  endtask

  initial begin
    logic [15:0] r, la, es, sd, sum_exp;
    int beats, se, he, zc, dg, n, done_seen;

    rst = 1'b1;
    bus.daddr = '0; bus.ddout = '0; bus.doe = 1'b0; bus.dwe0 = 1'b0; bus.dwe1 = 1'b0;
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    step();
    step();
    chk("rst_led", bus.led, 24'h000000);
    chk("rst_vld", bus.dump_valid, 0);
    chk("rst_busy", bus.dump_busy, 0);
    chk("rst_done", bus.dump_done, 0);
    chk("rst_sum", bus.dump_sum, 16'h0000);
    chk("rst_data", bus.dump_data, 16'h0000);
    chk("rst_addr", bus.dump_addr, 16'h0000);
    rst = 1'b0;
    step();

    // LED register; 0x201/0x203 are ordinary memory words aliasing the LED word bytes
    wr(16'h0201, 16'h1122, 1'b1, 1'b1);
    wr(16'h0203, 16'h3344, 1'b1, 1'b1);
    wr(16'h0200, 16'h00a5, 1'b0, 1'b1);
    wr(16'h0200, 16'h3c00, 1'b1, 1'b0);
    wr(16'h0202, 16'h0077, 1'b0, 1'b1);
    wr(16'h0202, 16'hff00, 1'b1, 1'b0);
    chk("led", bus.led, 24'h773ca5);
    rd(16'h0200, r); chk("ddin_led_lo", r, 16'h3ca5);
    rd(16'h0202, r); chk("ddin_led_hi", r, 16'h0077);
    rd(16'h0201, r); chk("mem_200", r, 16'h1122);
    rd(16'h0203, r); chk("mem_202", r, 16'h3344);
    bus.daddr = 16'h0200; #1;
    chk("ddin_doe0", bus.ddin, 16'h0000);

    // byte lanes
    wr(16'hc010, 16'hbeef, 1'b1, 1'b1);
    rd(16'hc011, r); chk("both_lanes", r, 16'hbeef);
    wr(16'hc012, 16'h5678, 1'b1, 1'b1);
    wr(16'hc012, 16'h1234, 1'b1, 1'b0);
    rd(16'hc012, r); chk("dwe0_only", r, 16'h1278);

    // full dump, sink always ready
    fill(1'b1);
    run_dump(1'b0, beats, se, he, zc, dg, la, es, sd);
    chk("full_beats", beats, 8192);
    chk("full_seq", se, 0);
    chk("full_zero", zc, 0);
    chk("full_last", la, 16'hfffe);
    chk("full_done_gap", dg, 1);
`ifdef RISC16_DUMP_CHECKSUM_EN
    sum_exp = es;
`else
    sum_exp = 16'h0000;
`endif
    chk("full_sum", sd, sum_exp);
    step();
    chk("done_1cyc", bus.dump_done, 0);
    chk("idle_busy", bus.dump_busy, 0);

    // coherency, ignored start, reset abort
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    chk("coh_first", bus.dump_addr, 16'hc000);
    bus.dump_ready = 1'b1;
    wr(16'hc002, 16'hffff, 1'b1, 1'b1);
    model[1] = 16'hffff;
    chk("coh_addr", bus.dump_addr, 16'hc002);
    chk("coh_old", bus.dump_data, 16'hc002);
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    chk("start_ign_addr", bus.dump_addr, 16'hc004);
    chk("start_ign_busy", bus.dump_busy, 1);
    n = 0;
    while (bus.dump_addr != 16'hc0c8 && n < 200) begin
      step();
      n++;
    end
    chk("beat100", bus.dump_addr, 16'hc0c8);
    bus.dump_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("abort_vld", bus.dump_valid, 0);
    chk("abort_busy", bus.dump_busy, 0);
    chk("abort_addr", bus.dump_addr, 16'h0000);
    chk("abort_sum", bus.dump_sum, 16'h0000);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dump_done) done_seen++;
      step();
    end
    chk("abort_no_done", done_seen, 0);

    // restart with random sink stalls
    run_dump(1'b1, beats, se, he, zc, dg, la, es, sd);
    chk("stall_beats", beats, 8192);
    chk("stall_seq", se, 0);
    chk("stall_hold", he, 0);
    chk("stall_done_gap", dg, 1);
`ifdef RISC16_DUMP_CHECKSUM_EN
    sum_exp = es;
`else
    sum_exp = 16'h0000;
`endif
    chk("stall_sum", sd, sum_exp);
    step();

    // all-ones data: sum of 8192 words of 0x0001
    fill(1'b0);
    run_dump(1'b0, beats, se, he, zc, dg, la, es, sd);
    chk("ones_beats", beats, 8192);
`ifdef RISC16_DUMP_CHECKSUM_EN
    sum_exp = 16'h2000;
`else
    sum_exp = 16'h0000;
`endif
    chk("ones_sum", sd, sum_exp);
    step();
    chk("ones_sum_hold", bus.dump_sum, sum_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc16ba_dbus.md
Name: risc16ba_dbus

Overview:
- Data-side bus slave directly downstream of the risc16ba core's data port.
- Holds 64 KiB byte-lane data memory, the 24-bit LED register at 0x200/0x202, and a dump engine.
- The dump engine streams a result region (default 0xc000..0xfffe) out as 16-bit words over a valid/ready handshake after the program finishes.
- Sits between the core and the board-level LED/host-readout logic.

Parameters:
- LED_ADDR_LO, 16'h0200, word address of led[15:0]
- LED_ADDR_HI, 16'h0202, word address of led[23:16]
- DUMP_BASE, 16'hc000, first byte address streamed; must be even
- DUMP_LAST, 16'hfffe, last word address streamed; even, >= DUMP_BASE

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- daddr  in  16  core data byte address
- ddout  in  16  core write data
- ddin  out  16  core read data
- doe  in  1  core read enable
- dwe0  in  1  write ddout[15:8] to byte (daddr & ~1)
- dwe1  in  1  write ddout[7:0] to byte (daddr | 1)
- led  out  24  LED register
- dump_start  in  1  single-cycle request to start a dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump_data/dump_addr valid
- dump_ready  in  1  sink accepts the current word
- dump_data  out  16  streamed word, {mem[a], mem[a+1]}
- dump_addr  out  16  byte address of dump_data
- dump_done  out  1  one-cycle pulse after the last word is accepted
- dump_sum  out  16  checksum (see Optional Feature)

Behaviour:
- Reset: led, dump_valid, dump_busy, dump_done and dump_sum go to 0; dump_data/dump_addr go to 0; FSM goes to IDLE. Memory contents are not reset.
- Reset mid-dump aborts the dump immediately. No dump_done pulse is generated.
- Memory is big-endian within a word.
  - Writes commit at the clock edge.
  - dwe0 and dwe1 are independent and may both be high in the same cycle.
- LED writes:
  - daddr==LED_ADDR_LO: dwe1 sets led[7:0], dwe0 sets led[15:8].
  - daddr==LED_ADDR_HI: dwe1 sets led[23:16]; dwe0 is ignored.
  - Writes to either LED address never modify memory.
- ddin is combinational, same cycle as doe:
  - doe=0: 16'h0000.
  - daddr==LED_ADDR_LO: led[15:0].
  - daddr==LED_ADDR_HI: {8'h00, led[23:16]}.
  - Otherwise: {mem[daddr&~1], mem[daddr|1]}.
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE + dump_start: load word at DUMP_BASE into dump_data, set dump_addr=DUMP_BASE, dump_valid=1, dump_busy=1, go to STREAM. First word is valid on the cycle after start.
  - STREAM, valid&&ready, dump_addr!=DUMP_LAST: load the next word (addr+2) at the same edge. Throughput is 1 word/cycle.
  - STREAM, valid&&ready, dump_addr==DUMP_LAST: clear dump_valid and dump_busy, go to DONE. The last-word check happens before increment, so 0xfffe never wraps to 0.
  - STREAM, valid&&!ready: dump_data and dump_addr are held stable.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
- dump_start in STREAM or DONE is ignored.
- Coherency: a word is sampled when it is loaded into dump_data.
  - A core write in the same cycle as the load is not seen by that load; the old value is streamed.
  - Later core writes do not alter a held word.

Optional Feature:
- Macro RISC16_DUMP_CHECKSUM_EN.
- Defined:
  - dump_sum clears on dump_start.
  - It accumulates (mod 2^16) each accepted word.
  - It is final and stable from the dump_done cycle until the next dump_start.
- Undefined: dump_sum is tied to 16'h0000 and no adder is built.

Decomposition:
- Package risc16ba_dbus_pkg holds:
  - default address constants (LED_ADDR_LO/HI, DUMP_BASE/LAST)
  - enum dump_state_t {IDLE, STREAM, DONE}
- Sub-module risc16ba_dump_fsm contains the FSM, address counter, output register and optional checksum. It reads memory through one combinational read port supplied by the parent.
- Memory, byte-lane writes, LED decode and ddin mux stay in the parent.

Test Plan:
- dwe1 at 0x200 with ddout=0x00a5, then dwe0 at 0x200 with ddout=0x3c00, then dwe1 at 0x202 with ddout=0x0077 -> led=0x773ca5; mem[0x200..0x203] unchanged; ddin at 0x200 = 0x3ca5.
- dwe0 and dwe1 together at 0xc010 with ddout=0xbeef, then doe at 0xc011 -> ddin=0xbeef; dwe0 only at 0xc012 with 0x1234 -> mem[0xc012]=0x12, mem[0xc013] unchanged.
- Fill the region with word = addr; dump_start; dump_ready held 1 -> 8192 consecutive beats, dump_data==dump_addr, last beat 0xfffe; dump_done pulses one cycle later; dump_addr never 0x0000.
- Random dump_ready stalls -> dump_data/dump_addr stable while valid&&!ready; no word lost or duplicated.
- Core writes 0xffff to 0xc002 in the same cycle 0xc002 is loaded -> old value streamed; dump_start pulsed mid-dump -> ignored.
- rst asserted at beat 100 -> next cycle: valid=0, busy=0, no done pulse; a new dump_start restarts at 0xc000. With RISC16_DUMP_CHECKSUM_EN and all-0x0001 data -> dump_sum=0x2000 at done.
